// File: rtl/sw_cmd_frame_loader_if.sv
// ---------------------------------------------------------------------------
// sw_cmd_frame_loader_if
// Bundles the software command PIO pair, the status PIO and the renderer read
// port of sw_cmd_frame_loader.
//   to_hw_sig    [1:0]      command from software (00 idle/01 WRITE/10 COMMIT/11 CLEAR)
//   to_hw_port   [DATA_W]   data word from software
//   to_sw_sig    [1:0]      status back to software (00 idle/01 ok/10 error)
//   rd_addr      [AW]       renderer read address into the front buffer
//   rd_data      [DATA_W]   registered front-buffer word
//   active_count [AW+1]     valid entries in the front buffer
//   frame_commit            one-cycle pulse when a new frame becomes front
//   overflow                sticky WRITE-while-full flag
// master: software/renderer side. slave: the loader.
// ---------------------------------------------------------------------------
interface sw_cmd_frame_loader_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 4
) ();
    logic [1:0]        to_hw_sig;
    logic [DATA_W-1:0] to_hw_port;
    logic [1:0]        to_sw_sig;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [AW:0]       active_count;
    logic              frame_commit;
    logic              overflow;

    modport master (
        output to_hw_sig, to_hw_port, rd_addr,
        input  to_sw_sig, rd_data, active_count, frame_commit, overflow
    );

    modport slave (
        input  to_hw_sig, to_hw_port, rd_addr,
        output to_sw_sig, rd_data, active_count, frame_commit, overflow
    );
endinterface

// File: rtl/sw_cmd_frame_loader.sv
// ---------------------------------------------------------------------------
// sw_cmd_frame_loader
// Consumes the 4-phase software command handshake, loads object words into
// the back half of a double-buffered table, swaps halves on COMMIT and serves
// the front half to the renderer through a registered read port.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      sw_cmd_frame_loader_if.slave (command/status PIOs, read port,
//            active_count, frame_commit, overflow)
// ---------------------------------------------------------------------------
module sw_cmd_frame_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sw_cmd_frame_loader_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ACK  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0]  CMD_IDLE    = 2'b00;
    localparam logic [1:0]  CMD_WRITE   = 2'b01;
    localparam logic [1:0]  CMD_COMMIT  = 2'b10;
    localparam logic [1:0]  CMD_CLEAR   = 2'b11;
    localparam logic [1:0]  STATUS_IDLE = 2'b00;
    localparam logic [1:0]  STATUS_OK   = 2'b01;
    localparam logic [1:0]  STATUS_ERR  = 2'b10;
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE     = (AW+1)'(1);
    localparam logic [1:0]  FILL_DONE   = 2'd3;

    // Command synchronizer and qualifier
    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    logic [1:0]        prev_r;
    logic [1:0]        cmd_hold_r;
    logic [1:0]        fill_r;
    logic [1:0]        cmd_q_s;
    logic              sync_full_s;

    // Control state
    state_t            state_r;
    logic              armed_r;
    logic [1:0]        cmd_r;
    logic [DATA_W-1:0] data_r;
    logic [AW:0]       wr_ptr_r;
    logic              front_sel_r;
    logic [AW:0]       active_count_r;
    logic              frame_commit_r;
    logic              overflow_r;
    logic [1:0]        to_sw_sig_r;
    logic [DATA_W-1:0] rd_data_r;

    // Storage: lower half selected by sel=0, upper half by sel=1
    logic [DATA_W-1:0] mem_r [0:2*DEPTH-1];
    logic              we_s;
    logic [AW:0]       wr_addr_s;
    logic [AW:0]       rd_idx_s;
    logic              rd_hit_s;

    // Qualified command: only a value seen on two consecutive synchronized
    // samples replaces the previously qualified one, so PIO bit skew never
    // produces a phantom intermediate command.
    always_comb begin
        cmd_q_s = cmd_hold_r;
        if (sync2_r == prev_r) begin
            cmd_q_s = sync2_r;
        end else begin
            cmd_q_s = cmd_hold_r;
        end
    end

    // The qualifier output is meaningless until real samples have filled the
    // whole pipeline; arming on reset-value zeros would let a command held
    // across reset replay itself.
    assign sync_full_s = (fill_r == FILL_DONE);

    // Write into the back half, read from the front half
    always_comb begin
        we_s      = 1'b0;
        wr_addr_s = {~front_sel_r, wr_ptr_r[AW-1:0]};
        rd_idx_s  = {front_sel_r, bus.rd_addr};
        rd_hit_s  = ({1'b0, bus.rd_addr} < active_count_r);
        if ((state_r == ST_EXEC) && (cmd_r == CMD_WRITE) && (wr_ptr_r < FULL_CNT)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Two-flop synchronizer, qualifier history and pipeline fill tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r    <= 2'b00;
            sync2_r    <= 2'b00;
            prev_r     <= 2'b00;
            cmd_hold_r <= 2'b00;
            fill_r     <= 2'd0;
        end else begin
            sync1_r    <= bus.to_hw_sig;
            sync2_r    <= sync1_r;
            prev_r     <= sync2_r;
            cmd_hold_r <= cmd_q_s;
            if (fill_r != FILL_DONE) begin
                fill_r <= fill_r + 2'd1;
            end else begin
                fill_r <= fill_r;
            end
        end
    end

    // Handshake FSM with all software/renderer-visible control outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            armed_r        <= 1'b0;
            cmd_r          <= CMD_IDLE;
            data_r         <= {DATA_W{1'b0}};
            wr_ptr_r       <= {(AW+1){1'b0}};
            front_sel_r    <= 1'b0;
            active_count_r <= {(AW+1){1'b0}};
            frame_commit_r <= 1'b0;
            overflow_r     <= 1'b0;
            to_sw_sig_r    <= STATUS_IDLE;
        end else begin
            frame_commit_r <= 1'b0;
            if (!armed_r && sync_full_s && (cmd_q_s == CMD_IDLE)) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (armed_r && (cmd_q_s != CMD_IDLE)) begin
                        data_r  <= bus.to_hw_port;
                        cmd_r   <= cmd_q_s;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_ACK;
                    case (cmd_r)
                        CMD_WRITE: begin
                            if (wr_ptr_r < FULL_CNT) begin
                                wr_ptr_r    <= wr_ptr_r + PTR_ONE;
                                to_sw_sig_r <= STATUS_OK;
                            end else begin
                                overflow_r  <= 1'b1;
                                to_sw_sig_r <= STATUS_ERR;
                            end
                        end
                        CMD_COMMIT: begin
                            front_sel_r    <= ~front_sel_r;
                            active_count_r <= wr_ptr_r;
                            wr_ptr_r       <= {(AW+1){1'b0}};
                            frame_commit_r <= 1'b1;
                            to_sw_sig_r    <= STATUS_OK;
                        end
                        CMD_CLEAR: begin
                            wr_ptr_r       <= {(AW+1){1'b0}};
                            active_count_r <= {(AW+1){1'b0}};
                            overflow_r     <= 1'b0;
                            to_sw_sig_r    <= STATUS_OK;
                        end
                        default: begin
                            // cmd_r is never idle here; report it as an error
                            to_sw_sig_r <= STATUS_ERR;
                        end
                    endcase
                end
                ST_ACK: begin
                    // Status is held; any other nonzero command is ignored
                    if (cmd_q_s == CMD_IDLE) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    to_sw_sig_r <= STATUS_IDLE;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    to_sw_sig_r <= STATUS_IDLE;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Back-buffer write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wr_addr_s] <= data_r;
        end
    end

    // Registered front-buffer read; entries past active_count read as zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_hit_s) begin
            rd_data_r <= mem_r[rd_idx_s];
        end else begin
            rd_data_r <= {DATA_W{1'b0}};
        end
    end

    assign bus.to_sw_sig    = to_sw_sig_r;
    assign bus.rd_data      = rd_data_r;
    assign bus.active_count = active_count_r;
    assign bus.frame_commit = frame_commit_r;
    assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_sw_cmd_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_sw_cmd_frame_loader
// Scoreboard bench: stimulus tasks push the expected acknowledge code and the
// expected read words into queues; monitor processes pop and compare when the
// loader raises a status or returns a read word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sw_cmd_frame_loader;

    localparam logic [1:0] C_IDLE   = 2'b00;
    localparam logic [1:0] C_WRITE  = 2'b01;
    localparam logic [1:0] C_COMMIT = 2'b10;
    localparam logic [1:0] C_CLEAR  = 2'b11;
    localparam logic [1:0] S_OK     = 2'b01;
    localparam logic [1:0] S_ERR    = 2'b10;

    logic clk;
    logic reset_n;
    logic rd_en;
    logic rd_en_d;
    int   total;
    int   bad;
    int   fc_cnt;

    logic [1:0]  ack_q [$];
    logic [31:0] rd_q  [$];

    sw_cmd_frame_loader_if #(.DATA_W(32), .AW(4)) bus ();

    sw_cmd_frame_loader #(.DATA_W(32), .DEPTH(16), .AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // read-issue delay line
    initial begin
        rd_en_d = 1'b0;
        forever begin
            @(posedge clk);
            rd_en_d = rd_en;
        end
    end

    // monitor: acknowledges, read words, frame_commit pulses
    initial begin
        logic [1:0] prev_sw;
        prev_sw = 2'b00;
        fc_cnt  = 0;
        forever begin
            @(negedge clk);
            if (prev_sw == 2'b00 && bus.to_sw_sig != 2'b00) begin
                if (ack_q.size() == 0) chk("unexpected_ack", {30'd0, bus.to_sw_sig}, 32'd0);
                else                   chk("ack", {30'd0, bus.to_sw_sig}, {30'd0, ack_q.pop_front()});
            end
            prev_sw = bus.to_sw_sig;
            if (rd_en_d) begin
                if (rd_q.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
                else                  chk("rd_data", bus.rd_data, rd_q.pop_front());
            end
            if (bus.frame_commit) fc_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_sw(input bit nz);
        int n;
        n = 0;
        while (((bus.to_sw_sig != 2'b00) != nz) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_timeout", (n >= 40) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [31:0] d, input logic [1:0] exp);
        @(negedge clk);
        bus.to_hw_port = d;
        bus.to_hw_sig  = c;
        ack_q.push_back(exp);
        wait_sw(1'b1);
        bus.to_hw_sig = C_IDLE;
        wait_sw(1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] e);
        @(negedge clk);
        bus.rd_addr = a;
        rd_en       = 1'b1;
        rd_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int  fc0;
        bit  seen;
        logic [31:0] words [3];
        words[0] = 32'h0000_00A1;
        words[1] = 32'h0000_00B2;
        words[2] = 32'h0000_00C3;
        total = 0;
        bad   = 0;
        rd_en = 1'b0;
        bus.to_hw_sig  = C_IDLE;
        bus.to_hw_port = 32'd0;
        bus.rd_addr    = 4'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_to_sw_sig",    {30'd0, bus.to_sw_sig}, 32'd0);
        chk("rst_rd_data",      bus.rd_data, 32'd0);
        chk("rst_active_count", {27'd0, bus.active_count}, 32'd0);
        chk("rst_frame_commit", {31'd0, bus.frame_commit}, 32'd0);
        chk("rst_overflow",     {31'd0, bus.overflow}, 32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // basic three-word frame
        for (int i = 0; i < 3; i++) do_cmd(C_WRITE, words[i], S_OK);
        fc0 = fc_cnt;
        do_cmd(C_COMMIT, 32'd0, S_OK);
        chk("t1_frame_commit_cnt", fc_cnt - fc0, 32'd1);
        chk("t1_active_count", {27'd0, bus.active_count}, 32'd3);
        for (int i = 0; i < 3; i++) do_read(i[3:0], words[i]);
        do_read(4'd3, 32'd0);

        // fill to DEPTH, then one overflowing write
        for (int i = 0; i < 17; i++) begin
            do_cmd(C_WRITE, 32'h1000_0000 + i, (i < 16) ? S_OK : S_ERR);
            if (i == 15) chk("t2_overflow_at_full", {31'd0, bus.overflow}, 32'd0);
        end
        chk("t2_overflow_set", {31'd0, bus.overflow}, 32'd1);
        do_cmd(C_COMMIT, 32'd0, S_OK);
        chk("t2_active_count_full", {27'd0, bus.active_count}, 32'd16);
        do_read(4'd0,  32'h1000_0000);
        do_read(4'd15, 32'h1000_000F);
        do_cmd(C_CLEAR, 32'd0, S_OK);
        chk("t2_overflow_clear", {31'd0, bus.overflow}, 32'd0);
        chk("t2_active_count_clear", {27'd0, bus.active_count}, 32'd0);
        for (int i = 0; i < 16; i++) do_read(i[3:0], 32'd0);

        // double buffering
        do_cmd(C_WRITE, 32'hAA00_0001, S_OK);
        do_cmd(C_WRITE, 32'hAA00_0002, S_OK);
        do_cmd(C_COMMIT, 32'd0, S_OK);
        do_cmd(C_WRITE, 32'hBB00_0001, S_OK);
        do_read(4'd0, 32'hAA00_0001);
        do_read(4'd1, 32'hAA00_0002);
        chk("t3_active_before", {27'd0, bus.active_count}, 32'd2);
        do_cmd(C_COMMIT, 32'd0, S_OK);
        chk("t3_active_after", {27'd0, bus.active_count}, 32'd1);
        do_read(4'd0, 32'hBB00_0001);
        do_read(4'd1, 32'd0);

        // skew glitch then command switch during ACK
        do_cmd(C_WRITE, 32'hDD00_0001, S_OK);
        fc0 = fc_cnt;
        @(negedge clk);
        bus.to_hw_sig = C_WRITE;
        ack_q.push_back(S_OK);
        @(negedge clk);
        bus.to_hw_sig = C_CLEAR;
        wait_sw(1'b1);
        bus.to_hw_sig = C_COMMIT;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.to_sw_sig != S_OK) seen = 1'b1;
        end
        chk("t4_ack_held", {31'd0, seen}, 32'd0);
        bus.to_hw_sig = C_IDLE;
        wait_sw(1'b0);
        repeat (2) @(negedge clk);
        chk("t4_clear_executed", {27'd0, bus.active_count}, 32'd0);
        chk("t4_no_commit", fc_cnt - fc0, 32'd0);

        // reset while in ACK with WRITE held
        @(negedge clk);
        bus.to_hw_port = 32'hEE00_0001;
        bus.to_hw_sig  = C_WRITE;
        ack_q.push_back(S_OK);
        wait_sw(1'b1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("t5_async_reset", {30'd0, bus.to_sw_sig}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.to_sw_sig != 2'b00) seen = 1'b1;
        end
        chk("t5_no_replay", {31'd0, seen}, 32'd0);
        bus.to_hw_sig = C_IDLE;
        repeat (5) @(negedge clk);
        do_cmd(C_WRITE, 32'hEE00_0002, S_OK);
        do_cmd(C_COMMIT, 32'd0, S_OK);
        chk("t5_single_write", {27'd0, bus.active_count}, 32'd1);
        do_read(4'd0, 32'hEE00_0002);
        do_read(4'd1, 32'd0);

        // latency
        @(negedge clk);
        bus.to_hw_port = 32'h5555_0001;
        bus.to_hw_sig  = C_WRITE;
        ack_q.push_back(S_OK);
        repeat (4) @(negedge clk);
        chk("t6_lat_cycle4", {30'd0, bus.to_sw_sig}, 32'd0);
        @(negedge clk);
        chk("t6_lat_cycle5", {30'd0, bus.to_sw_sig}, 32'd1);
        repeat (5) @(negedge clk);
        bus.to_hw_sig = C_IDLE;
        repeat (5) @(negedge clk);
        chk("t6_release", {30'd0, bus.to_sw_sig}, 32'd0);

        repeat (5) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 32'd0);
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_cmd_frame_loader.md
Name: sw_cmd_frame_loader

Overview:
- Hardware-side consumer of the 2-bit software-to-hardware command PIO and its companion data PIO.
- Decodes a 4-phase handshake driven by the Nios software and loads data words into a double-buffered object table.
- Commits a finished frame to the display-facing buffer and acknowledges each command back to software over a 2-bit status PIO input.
- The renderer reads the committed (front) buffer through a registered read port.

Parameters:
- DATA_W, 32, width of each object word and of to_hw_port.
- DEPTH, 16, entries per buffer; must be a power of two.
- AW, 4, address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- to_hw_sig  in  2  command from software PIO: 00 idle, 01 WRITE, 10 COMMIT, 11 CLEAR.
- to_hw_port  in  DATA_W  data word from software PIO; software sets it before issuing WRITE.
- to_sw_sig  out  2  status to software PIO: 00 idle, 01 ack-ok, 10 ack-error.
- rd_addr  in  AW  renderer read address into the front buffer.
- rd_data  out  DATA_W  front-buffer word, registered.
- active_count  out  AW+1  number of valid entries in the front buffer.
- frame_commit  out  1  one-cycle pulse when a new frame becomes front.
- overflow  out  1  sticky flag: a WRITE was attempted while the back buffer was full.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
- Reset values: to_sw_sig=00, rd_data=0, active_count=0, frame_commit=0, overflow=0, wr_ptr=0, front_sel=0, armed=0, state=IDLE. Buffer RAM contents are not reset.
- Input sync: to_hw_sig passes through a 2-flop synchronizer. The command is qualified only when two consecutive synchronized samples are equal (cmd_q), which rejects PIO bit skew.
- Arming: after reset, armed=0 and all commands are ignored until cmd_q==00 has been seen once. This prevents replaying a command that was in flight across a reset.
- State IDLE: if armed and cmd_q!=00, to_hw_port is captured into data_q and the FSM goes to EXEC. Capture happens on the same edge.
- State EXEC (one cycle), by command:
  - WRITE, wr_ptr<DEPTH: back[wr_ptr]<=data_q, wr_ptr++, status=01.
  - WRITE, wr_ptr==DEPTH: no write, overflow<=1, status=10.
  - COMMIT: front_sel<=~front_sel, active_count<=wr_ptr, wr_ptr<=0, frame_commit=1 for this cycle only, status=01. A COMMIT with wr_ptr==0 is legal and yields active_count=0.
  - CLEAR: wr_ptr<=0, active_count<=0, overflow<=0, status=01. front_sel is unchanged.
  - After any command, go to ACK.
- State ACK: to_sw_sig driven with status, held.
  - Any nonzero cmd_q, including a different command, is ignored (protocol violation, no action).
  - When cmd_q==00, go to DONE.
- State DONE: to_sw_sig<=00, go to IDLE. A new command can be accepted on the cycle after reaching IDLE.
- Latency: from a stable to_hw_sig change to to_sw_sig nonzero is 5 clk cycles: sync 2, qualify 1, IDLE capture 1, EXEC 1. Release from to_hw_sig=00 to to_sw_sig=00 is 4–5 cycles.
- wr_ptr is AW+1 bits wide and saturates at DEPTH; it never wraps.
- Read port, 1-cycle latency:
  - rd_data <= (rd_addr < active_count) ? front[rd_addr] : 0.
  - Front and active_count are sampled at the read edge. A read issued on the COMMIT cycle returns old-frame data; the next read returns new-frame data.
- Buffer storage: two DEPTH x DATA_W arrays, or one 2*DEPTH array addressed by {sel, addr}. The write port addresses the back buffer (~front_sel); the read port addresses the front buffer. A single-clock simple dual-port memory suffices, because write and read never target the same half.
- Reset mid-handshake: the FSM returns to IDLE, to_sw_sig=00 immediately (async), armed=0. Software must drop the command to 00 before it is re-accepted.

Test Plan:
- Reset, then WRITE three words 0xA1, 0xB2, 0xC3 each with full handshake, then COMMIT -> to_sw_sig=01 for each command; frame_commit pulses once; active_count=3; rd_addr 0..3 returns 0xA1, 0xB2, 0xC3, 0x0.
- DEPTH+1 WRITEs (17) -> first 16 ack 01; 17th ack 10 with overflow=1. COMMIT -> active_count=16. CLEAR -> overflow=0, active_count=0, rd_data=0 for all addresses.
- Double buffer: commit frame A (2 words), then WRITE 1 word of frame B without commit -> reads still return frame A. COMMIT -> active_count=1 and reads return the frame B word.
- Skew/violation: drive to_hw_sig 00->01->11 with a 1-cycle glitch at 01 -> only CLEAR executes. While in ACK, switch the command 11->10 -> no COMMIT occurs and to_sw_sig stays 01 until 00.
- Assert reset_n low while in ACK with to_hw_sig=01 held -> to_sw_sig=00 asynchronously; no new write after release. Drop to 00, then reissue WRITE -> it executes once with ack 01.
- Timing: single WRITE with to_hw_sig changing at cycle 0 -> to_sw_sig=01 at cycle 5. to_hw_sig=00 at cycle 10 -> to_sw_sig=00 by cycle 15.
